// File: rtl/conv2_sched.sv
// conv2_sched: layer-pass sequencer for the conv2 datapath (fetch, launch, wait, accumulate, hand off).
// Optional busy-cycle counter enabled with `define CONV2_SCHED_PERF_EN.
module conv2_sched #(
    parameter int NUM_PAIRS = 9,
    parameter int DP_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [3:0]  pair_idx,
    output logic        ker_req,
    input  logic        ker_ack,
    output logic        dp_valid,
    output logic        acc_en,
    output logic        acc_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] perf_cycles
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LAUNCH, WAIT, ACCUM, OUTPUT
    } state_t;

    localparam logic [3:0] LAST  = 4'(NUM_PAIRS - 1);
    localparam logic [3:0] WLOAD = 4'(DP_LAT - 1);

    state_t     state;
    logic [3:0] wcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pair_idx  <= '0;
            wcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ker_req   <= 1'b0;
            dp_valid  <= 1'b0;
            acc_en    <= 1'b0;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            dp_valid <= 1'b0;
            acc_en   <= 1'b0;
            acc_clr  <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                ker_req   <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FETCH;
                            pair_idx <= '0;
                            busy     <= 1'b1;
                            ker_req  <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (ker_ack) begin
                            state    <= LAUNCH;
                            ker_req  <= 1'b0;
                            dp_valid <= 1'b1;
                        end
                    end
                    LAUNCH: begin
                        state <= WAIT;
                        wcnt  <= WLOAD;
                    end
                    WAIT: begin
                        if (wcnt == 4'd0) begin
                            state   <= ACCUM;
                            acc_en  <= 1'b1;
                            acc_clr <= (pair_idx == 4'd0);
                        end else begin
                            wcnt <= wcnt - 4'd1;
                        end
                    end
                    ACCUM: begin
                        if (pair_idx == LAST) begin
                            state     <= OUTPUT;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            pair_idx <= pair_idx + 4'd1;
                            ker_req  <= 1'b1;
                        end
                    end
                    OUTPUT: begin
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CONV2_SCHED_PERF_EN
    logic [15:0] pcnt;

    // Cleared on start acceptance; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (state == IDLE && start) begin
            pcnt <= '0;
        end else if (busy && pcnt != 16'hFFFF) begin
            pcnt <= pcnt + 16'd1;
        end
    end

    assign perf_cycles = pcnt;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv2_sched.sv
// tb_conv2_sched: directed table-driven bench for conv2_sched (default parameters).
// Define CONV2_SCHED_PERF_EN for both RTL and bench to check the perf counter.
module tb_conv2_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [3:0]  pair_idx;
    logic        ker_req;
    logic        ker_ack;
    logic        dp_valid;
    logic        acc_en;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] perf_cycles;

    int total = 0;
    int bad   = 0;

    conv2_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .pair_idx   (pair_idx),
        .ker_req    (ker_req),
        .ker_ack    (ker_ack),
        .dp_valid   (dp_valid),
        .acc_en     (acc_en),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ap;
        int ad;
        int rd;
        int exp_ov;
        int exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_perf(input int n);
`ifdef CONV2_SCHED_PERF_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic int strobes();
        return {28'd0, ker_req, dp_valid, acc_en, acc_clr}
             | {25'd0, out_valid, busy, done, 4'd0};
    endfunction

    // One full pass: ker_ack low for the first ad FETCH cycles of pair ap,
    // out_ready low for the first rd OUTPUT cycles; stray starts mid-pass.
    task automatic run_pass(input vec_t v);
        int c = 0, kr = 0, dpn = 0, aen = 0, clr = 0;
        int ovf = -1, ovl = 0, dc = -1, seqbad = 0, pf = -1;
        start = 1'b1;
        while (dc < 0 && c < 300) begin
            @(negedge clk);
            c++;
            start   = (c == 10);
            ker_ack = 1'b1;
            if (ker_req && pair_idx == 4'(v.ap)) begin
                ker_ack = (kr >= v.ad);
                kr++;
            end
            if (dp_valid) dpn++;
            if (acc_en) begin
                if (pair_idx != 4'(aen)) seqbad++;
                if (acc_clr != (aen == 0)) seqbad++;
                aen++;
            end else if (acc_clr) begin
                seqbad++;
            end
            if (acc_clr) clr++;
            if (!done && !busy) seqbad++;
            if (out_valid) begin
                if (ovf < 0) ovf = c;
                ovl++;
                out_ready = (ovl > v.rd);
                start = 1'b1;
            end
            if (done) begin
                dc = c;
                pf = int'(perf_cycles);
                check("busy_at_done", int'(busy), 0);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        ker_ack = 1'b1;
        check("out_valid_cycle", ovf, v.exp_ov);
        check("done_cycle", dc, v.exp_done);
        check("out_valid_len", ovl, v.rd + 1);
        check("ker_req_len", kr, v.ad + 1);
        check("dp_valid_count", dpn, 9);
        check("acc_en_count", aen, 9);
        check("acc_clr_count", clr, 1);
        check("sequence_errs", seqbad, 0);
        check("perf_cycles", pf, exp_perf(v.exp_done - 1));
    endtask

    initial begin
        vecs[0] = '{ap: 0, ad: 0, rd: 0,  exp_ov: 46, exp_done: 47};
        vecs[1] = '{ap: 4, ad: 3, rd: 0,  exp_ov: 49, exp_done: 50};
        vecs[2] = '{ap: 0, ad: 0, rd: 10, exp_ov: 46, exp_done: 57};
        vecs[3] = '{ap: 0, ad: 2, rd: 0,  exp_ov: 48, exp_done: 49};
        vecs[4] = '{ap: 8, ad: 1, rd: 5,  exp_ov: 47, exp_done: 53};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ker_ack = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_strobes", strobes(), 0);
        check("reset_pair_idx", int'(pair_idx), 0);
        check("reset_perf", int'(perf_cycles), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_pass(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // abort during first WAIT cycle of pair 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !(dp_valid && pair_idx == 4'd2); i++)
            @(negedge clk);
        check("abort_reach", int'(dp_valid && pair_idx == 4'd2), 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_strobes", strobes(), 0);
        begin
            int stray = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (acc_en || done || busy) stray++;
            end
            check("abort_quiet", stray, 0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_pair_idx", int'(pair_idx), 0);
        check("restart_busy", int'(busy), 1);
        for (int i = 0; i < 20 && !acc_en; i++) @(negedge clk);
        check("restart_acc_clr", int'(acc_en && acc_clr), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        // reset in ACCUM of pair 7
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !(acc_en && pair_idx == 4'd7); i++)
            @(negedge clk);
        check("rst_reach", int'(acc_en && pair_idx == 4'd7), 1);
        rst = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        check("rst_strobes", strobes(), 0);
        check("rst_pair_idx", int'(pair_idx), 0);
        check("rst_perf", int'(perf_cycles), 0);
        @(negedge clk);
        check("rst_stays_idle", int'(busy), 0);

        // start coinciding with the done pulse
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("done_reach", int'(done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", int'(busy && ker_req), 1);
        check("done_start_pair", int'(pair_idx), 0);
        check("done_start_perf", int'(perf_cycles), exp_perf(0));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("final_idle", strobes(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv2_sched.md
CONV2_SCHED -- requirements
Module: conv2_sched

Interface
REQ-001 SHALL have parameter NUM_PAIRS, default 9: number of input-channel pairs sequenced per layer pass, legal range 1..15.
REQ-002 SHALL have parameter DP_LAT, default 2: fixed conv datapath latency in cycles, legal range 1..15.
REQ-003 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port start  in  1: request one full layer pass.
REQ-006 SHALL have port abort  in  1: cancel the pass in progress.
REQ-007 SHALL have port busy  out  1: high whenever the state is not IDLE.
REQ-008 SHALL have port done  out  1: one-cycle pulse on pass completion.
REQ-009 SHALL have port pair_idx  out  4: selects the image channel pair and the 120-kernel group fed to the datapath.
REQ-010 SHALL have port ker_req  out  1 and ker_ack  in  1: kernel-group fetch handshake.
REQ-011 SHALL have port dp_valid  out  1: launch strobe to the conv datapath.
REQ-012 SHALL have port acc_en  out  1 and acc_clr  out  1: partial-sum accumulator controls.
REQ-013 SHALL have port out_valid  out  1 and out_ready  in  1: result-map handoff handshake.
REQ-014 SHALL have port perf_cycles  out  16: busy-cycle counter (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LAUNCH, WAIT, ACCUM, OUTPUT.
REQ-016 IDLE: start=1 SHALL clear pair_idx to 0 and move to FETCH; start SHALL be ignored in every other state.
REQ-017 FETCH: ker_req=1; ker_ack=1 in that cycle (including the first FETCH cycle) SHALL move to LAUNCH; otherwise SHALL hold.
REQ-018 LAUNCH: dp_valid=1 for exactly one cycle, then SHALL move to WAIT.
REQ-019 WAIT: SHALL last exactly DP_LAT cycles via an internal down-counter, then SHALL move to ACCUM.
REQ-020 ACCUM: acc_en=1 for one cycle; acc_clr=1 in the same cycle iff pair_idx==0, so the first pair loads and later pairs add.
REQ-021 ACCUM with pair_idx==NUM_PAIRS-1 SHALL move to OUTPUT; otherwise SHALL increment pair_idx and move to FETCH.
REQ-022 OUTPUT: out_valid=1 held until out_ready=1; on the handshake cycle SHALL move to IDLE and assert done in the following cycle.
REQ-023 With ker_ack tied high, each pair SHALL take DP_LAT+3 cycles; OUTPUT SHALL be entered NUM_PAIRS*(DP_LAT+3) cycles after the first FETCH cycle.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with no done, no acc_en, and all strobes low; abort has priority over every transition.
REQ-025 ker_req, dp_valid, acc_en, acc_clr and out_valid SHALL be low outside their named states.
REQ-026 pair_idx SHALL hold its value outside ACCUM increments and SHALL never exceed NUM_PAIRS-1.
REQ-027 If start=1 coincides with the done-pulse cycle (IDLE), it SHALL be accepted normally.

Reset
REQ-028 rst=1 SHALL place the FSM in IDLE on the next edge, regardless of state, including mid-pass.
REQ-029 rst SHALL zero pair_idx, the WAIT counter and perf_cycles, and drive busy, done, ker_req, dp_valid, acc_en, acc_clr and out_valid to 0.
REQ-030 rst SHALL take priority over abort and start.

Configuration
REQ-031 With macro CONV2_SCHED_PERF_EN defined, perf_cycles SHALL count cycles with busy=1, clear on start acceptance, and saturate at 0xFFFF.
REQ-032 Without CONV2_SCHED_PERF_EN, perf_cycles SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification
REQ-033 Defaults, ker_ack=1, out_ready=1, single start pulse -> 9 dp_valid pulses at 5-cycle spacing; acc_clr only with the first acc_en; out_valid on cycle 46 after start; done one cycle after.
REQ-034 ker_ack delayed 3 cycles on pair 4 -> ker_req held 4 cycles for pair 4; total pass 3 cycles longer; pair_idx still steps 0..8.
REQ-035 out_ready low for 10 cycles in OUTPUT -> out_valid held 10+ cycles, no done until the handshake; start pulses during the pass are ignored.
REQ-036 abort during WAIT of pair 2 -> IDLE next cycle, busy=0, no acc_en or done; a new start restarts at pair_idx=0 with acc_clr.
REQ-037 rst asserted in ACCUM of pair 7 -> all outputs 0 next cycle; perf_cycles=0.
REQ-038 CONV2_SCHED_PERF_EN defined, default pass with immediate handshakes -> perf_cycles=46 after done; undefined -> perf_cycles stays 0.
